count_rate_detect: RTL

//  Receive-side partner of the programmable strobe generator. Measures the spacing of

---
 rtl/count_rate_detect.sv | 134 +++++++++++++
 1 files changed

// File: rtl/count_rate_detect.sv
// Strobe-rate detector: measures the enabled-cycle spacing of incoming strobes,
// decodes which of four rates is present, and reports lock, period and error pulses.
module count_rate_detect #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned R0         = 10,
  parameter int unsigned R1         = 20,
  parameter int unsigned R2         = 30,
  parameter int unsigned R3         = 40,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_strobe,
  output logic [1:0]       o_sel,
  output logic             o_locked,
  output logic             o_err,
  output logic [CNT_W-1:0] o_period,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int unsigned MC_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] L0  = CNT_W'(R0);
  localparam logic [CNT_W-1:0] L1  = CNT_W'(R1);
  localparam logic [CNT_W-1:0] L2  = CNT_W'(R2);
  localparam logic [CNT_W-1:0] L3  = CNT_W'(R3);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(R3 + 1);
  localparam logic [MC_W-1:0]  LCK = MC_W'(LOCK_COUNT);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_cand;
  logic [MC_W-1:0]   r_match_cnt;

  logic              w_hit;
  logic [1:0]        w_k;
  logic [CNT_W-1:0]  w_sel_lim;
  logic [MC_W-1:0]   w_mc_next;

  // Limits are distinct, so at most one rate can match a given count.
  always_comb begin
    w_hit = 1'b1;
    w_k   = 2'd0;
    if (r_cnt == L0)      w_k = 2'd0;
    else if (r_cnt == L1) w_k = 2'd1;
    else if (r_cnt == L2) w_k = 2'd2;
    else if (r_cnt == L3) w_k = 2'd3;
    else                  w_hit = 1'b0;
  end

  always_comb begin
    w_sel_lim = L0;
    case (o_sel)
      2'd0:    w_sel_lim = L0;
      2'd1:    w_sel_lim = L1;
      2'd2:    w_sel_lim = L2;
      default: w_sel_lim = L3;
    endcase
  end

  always_comb begin
    w_mc_next = MC_W'(1);
    if ((w_k == r_cand) && (r_match_cnt != '0)) w_mc_next = r_match_cnt + MC_W'(1);
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cand      <= 2'd0;
      r_match_cnt <= '0;
      o_sel       <= 2'd0;
      o_locked    <= 1'b0;
      o_err       <= 1'b0;
      o_period    <= '0;
    end else if (i_enable) begin
      o_err <= 1'b0;
      if (i_strobe) begin
        r_cnt <= '0;
        case (r_state)
          IDLE: begin
            r_match_cnt <= '0;
            r_state     <= MEASURE;
          end
          MEASURE: begin
            o_period <= r_cnt;
            if (w_hit) begin
              r_cand      <= w_k;
              r_match_cnt <= w_mc_next;
              if (w_mc_next >= LCK) begin
                o_sel    <= w_k;
                o_locked <= 1'b1;
                r_state  <= LOCKED;
              end
            end else begin
              o_err       <= 1'b1;
              r_match_cnt <= '0;
            end
          end
          LOCKED: begin
            if (r_cnt == w_sel_lim) begin
              o_period <= r_cnt;
            end else begin
              // A different valid rate counts as the first interval of a new candidate.
              o_err       <= 1'b1;
              o_locked    <= 1'b0;
              r_state     <= MEASURE;
              r_match_cnt <= w_hit ? MC_W'(1) : '0;
              if (w_hit) r_cand <= w_k;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_cnt == TMO) begin
        o_err    <= 1'b1;
        o_locked <= 1'b0;
        r_cnt    <= '0;
        r_state  <= IDLE;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_state = r_state;

endmodule
